// File: rtl/read_logic.sv
// Read side of a synchronous FIFO: tracks occupancy, drives the read address,
// registers the read word with a one-cycle pop strobe, and keeps sticky error flags.
module read_logic #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3,
  parameter int ALMOST_E  = 1,
  parameter int ALMOST_F  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_rd,
  input  logic                 fifo_wr,
  input  logic [WORD_SIZE-1:0] mem_rd_data,
  output logic [PTR_L-1:0]     rd_ptr,
  output logic                 pop,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 underflow,
  output logic                 overflow
);

  localparam logic [PTR_L-1:0] LP_DEPTH = PTR_L'(MEM_SIZE);
  localparam logic [PTR_L-1:0] LP_LAST  = PTR_L'(MEM_SIZE - 1);
  localparam logic [PTR_L-1:0] LP_AE    = PTR_L'(ALMOST_E);
  localparam logic [PTR_L-1:0] LP_AF    = PTR_L'(ALMOST_F);

  logic [PTR_L-1:0]     r_count;
  logic [PTR_L-1:0]     r_rd_ptr;
  logic                 r_pop;
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_underflow;
  logic                 r_overflow;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [PTR_L-1:0]     w_count_nxt;
  logic [PTR_L-1:0]     w_rd_ptr_nxt;

  function automatic logic [PTR_L-1:0] ptr_advance(input logic [PTR_L-1:0] p);
    if (p == LP_LAST) return '0;
    return p + PTR_L'(1);
  endfunction

  // A simultaneous accepted read and write leaves occupancy unchanged.
  function automatic logic [PTR_L-1:0] count_update(input logic [PTR_L-1:0] c,
                                                    input logic wr_acc,
                                                    input logic rd_acc);
    case ({wr_acc, rd_acc})
      2'b10:   return c + PTR_L'(1);
      2'b01:   return c - PTR_L'(1);
      default: return c;
    endcase
  endfunction

  // Flags depend only on registered occupancy, never on same-cycle requests.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);

  assign w_rd_acc     = fifo_rd && !w_empty;
  assign w_wr_acc     = fifo_wr && !w_full;
  assign w_count_nxt  = count_update(r_count, w_wr_acc, w_rd_acc);
  assign w_rd_ptr_nxt = w_rd_acc ? ptr_advance(r_rd_ptr) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_pop       <= 1'b0;
      r_data_out  <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_pop    <= w_rd_acc;
      if (w_rd_acc) r_data_out <= mem_rd_data;
      if (fifo_rd && w_empty) r_underflow <= 1'b1;
      if (fifo_wr && w_full)  r_overflow  <= 1'b1;
    end
  end

  assign rd_ptr       = r_rd_ptr;
  assign pop          = r_pop;
  assign data_out     = r_data_out;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_empty = (r_count <= LP_AE) && !w_empty;
  assign almost_full  = (r_count >= LP_AF) && !w_full;
  assign underflow    = r_underflow;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_read_logic.sv
// Bench for read_logic: emulates the write side and memory, checks data through a
// scoreboard queue, and checks occupancy flags against a table and a reference count.
module tb_read_logic;
  localparam int MEM_SIZE  = 4;
  localparam int WORD_SIZE = 6;
  localparam int PTR_L     = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fifo_rd = 1'b0;
  logic fifo_wr = 1'b0;
  logic [WORD_SIZE-1:0] mem_rd_data;
  logic [PTR_L-1:0]     rd_ptr;
  logic                 pop;
  logic [WORD_SIZE-1:0] data_out;
  logic fifo_empty, fifo_full, almost_empty, almost_full, underflow, overflow;

  logic [WORD_SIZE-1:0] tb_mem [MEM_SIZE];
  logic [WORD_SIZE-1:0] sb_q [$];
  int errors = 0;
  int checks = 0;
  int m_cnt = 0, m_wp = 0, m_rp = 0;
  bit m_uf = 0, m_of = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = (rd_ptr < PTR_L'(MEM_SIZE)) ? tb_mem[rd_ptr[1:0]] : '0;

  read_logic #(.MEM_SIZE(MEM_SIZE), .WORD_SIZE(WORD_SIZE), .PTR_L(PTR_L),
               .ALMOST_E(1), .ALMOST_F(3)) dut (
    .clk(clk), .reset(reset), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr),
    .mem_rd_data(mem_rd_data), .rd_ptr(rd_ptr), .pop(pop), .data_out(data_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
    .almost_full(almost_full), .underflow(underflow), .overflow(overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update the reference at posedge, compare #1 later.
  task automatic step(input logic rd, input logic wr, input logic rst = 1'b0);
    bit racc, wacc;
    logic [WORD_SIZE-1:0] w, exp_d;
    @(negedge clk);
    fifo_rd = rd;
    fifo_wr = wr;
    reset   = rst;
    racc = !rst && rd && (m_cnt != 0);
    wacc = !rst && wr && (m_cnt != MEM_SIZE);
    w = WORD_SIZE'($urandom_range(0, 63));
    if (wacc) begin
      tb_mem[m_wp] = w;
      sb_q.push_back(w);
      m_wp = (m_wp + 1) % MEM_SIZE;
    end
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_rp = 0; m_wp = 0; m_uf = 0; m_of = 0;
      sb_q.delete();
    end else begin
      if (rd && m_cnt == 0) m_uf = 1;
      if (wr && m_cnt == MEM_SIZE) m_of = 1;
      if (racc) m_rp = (m_rp + 1) % MEM_SIZE;
      m_cnt = m_cnt + int'(wacc) - int'(racc);
    end
    #1;
    chk("rd_ptr", int'(rd_ptr), m_rp);
    chk("pop", int'(pop), int'(racc));
    chk("fifo_empty", int'(fifo_empty), int'(m_cnt == 0));
    chk("fifo_full", int'(fifo_full), int'(m_cnt == MEM_SIZE));
    chk("almost_empty", int'(almost_empty), int'(m_cnt == 1));
    chk("almost_full", int'(almost_full), int'(m_cnt == 3));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("overflow", int'(overflow), int'(m_of));
    if (racc) begin
      if (sb_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        exp_d = sb_q.pop_front();
        chk("data_out", int'(data_out), int'(exp_d));
      end
    end
  endtask

  typedef struct {
    logic rd, wr;
    logic e_empty, e_full, e_ae, e_af, e_pop;
    int   e_ptr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // fill then drain at default parameters
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    for (int i = 0; i < MEM_SIZE; i++) tb_mem[i] = '0;

    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("reset_empty", int'(fifo_empty), 1);
    chk("reset_data_out", int'(data_out), 0);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rd, vecs[i].wr);
      chk($sformatf("vec%0d_empty", i), int'(fifo_empty), int'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i), int'(fifo_full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d_ae", i), int'(almost_empty), int'(vecs[i].e_ae));
      chk($sformatf("vec%0d_af", i), int'(almost_full), int'(vecs[i].e_af));
      chk($sformatf("vec%0d_pop", i), int'(pop), int'(vecs[i].e_pop));
      chk($sformatf("vec%0d_ptr", i), int'(rd_ptr), vecs[i].e_ptr);
    end

    // read while empty: no pop, sticky underflow
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("uf_set", int'(underflow), 1);
    chk("uf_no_pop", int'(pop), 0);
    chk("uf_ptr", int'(rd_ptr), 0);
    repeat (3) step(1'b0, 1'b0);
    chk("uf_held", int'(underflow), 1);
    // read+write while empty: write accepted, read rejected
    step(1'b1, 1'b1);
    chk("rw_empty_pop", int'(pop), 0);
    chk("rw_empty_ae", int'(almost_empty), 1);

    // write while full, then read+write while full
    step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("of_set", int'(overflow), 1);
    chk("of_still_full", int'(fifo_full), 1);
    step(1'b1, 1'b1);
    chk("rw_full_pop", int'(pop), 1);
    chk("rw_full_af", int'(almost_full), 1);
    chk("rw_full_notfull", int'(fifo_full), 0);

    // simultaneous read/write at count 2 for 10 cycles
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("rw2_ptr%0d", i), int'(rd_ptr), (i + 1) % MEM_SIZE);
      chk($sformatf("rw2_pop%0d", i), int'(pop), 1);
      chk($sformatf("rw2_mid%0d", i),
          int'({fifo_empty, fifo_full, almost_empty, almost_full}), 0);
    end

    // reset during a read burst at rd_ptr = 2, with overflow already set
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("burst_ptr2", int'(rd_ptr), 2);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_ptr", int'(rd_ptr), 0);
    chk("rst_pop", int'(pop), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_uf", int'(underflow), 0);
    chk("rst_of", int'(overflow), 0);
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
